bus_source_encoder: RTL
=======================

Name: bus_source_encoder

Overview:
- Control-side counterpart to the 32-to-1 datapath bus multiplexer.
- Takes the one-hot-intended "Xout" drive requests from control (R0out..R15out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InPortout, Cout) and produces the registered 5-bit bus select code.
- Arbitrates round-robin when more than one source requests, supports ownership hold, and flags and counts conflicts for debug.
- Guarantees the mux only ever sees select codes 0..23, never an undefined code.

Parameters:
- NUM_SRC, 24, number of bus sources; select codes 0..NUM_SRC-1.
- SEL_W, 5, width of the select code.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- out_req  in  NUM_SRC  drive requests; bit i corresponds to select code i (0..15 = R0..R15, 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLO, 20 = PC, 21 = MDR, 22 = InPort, 23 = C sign-extended).
- hold  in  1  current owner keeps the bus while it still requests.
- sel  out  SEL_W  registered select code to the bus mux.
- grant  out  NUM_SRC  registered one-hot grant; bit set equals sel when bus_valid.
- bus_valid  out  1  registered; bus currently carries a granted source.
- conflict  out  1  registered one-cycle pulse; more than one out_req bit was set in the previous cycle.
- conflict_count  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (clear=1 at an edge) forces the following values; clear overrides all other inputs that cycle, including mid-ownership:
  - sel = 0, grant = 0, bus_valid = 0, conflict = 0, conflict_count = 0.
  - Internal last-owner pointer = NUM_SRC-1, so the first arbitration favours code 0.
- States:
  - IDLE: bus_valid = 0.
  - OWNED: bus_valid = 1.
- Latency: a request sampled at edge N is reflected in sel/grant/bus_valid after edge N (one cycle).
- Next-state rules, evaluated on each edge with clear = 0:
  - OWNED, hold = 1, and out_req[sel] = 1: sel and grant unchanged; stay OWNED.
  - Otherwise, if out_req has any bit set: pick the first set bit scanning upward from last_owner+1, wrapping NUM_SRC-1 -> 0.
    - sel = that index; grant = one-hot of that index; bus_valid = 1; last_owner = index; enter or stay in OWNED.
  - Otherwise (out_req = 0): bus_valid = 0, grant = 0, enter IDLE.
    - sel holds its last value so the bus mux output stays deterministic.
    - last_owner is unchanged.
- In OWNED with hold = 0 and the owner still requesting alongside others: re-arbitrate each cycle. The owner is lowest priority next round, giving fairness.
- A single requester is granted every cycle regardless of the round-robin pointer.
- out_req bits at index >= NUM_SRC do not exist. sel is never driven to a value >= NUM_SRC.
- Conflicts:
  - conflict = 1 for exactly one cycle after any edge where popcount(out_req) >= 2, independent of hold.
  - conflict_count increments on each such cycle and saturates at 2^CNT_W-1 (no wrap).
- Invariant: bus_valid = 1 implies grant is one-hot and grant[sel] = 1; bus_valid = 0 implies grant = 0.

Decomposition:
- Shared package bus_pkg holds:
  - NUM_SRC, SEL_W.
  - Named source codes SRC_R0..SRC_R15 = 0..15, SRC_HI = 16, SRC_LO = 17, SRC_ZHI = 18, SRC_ZLO = 19, SRC_PC = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_CSIGN = 23.
  - State enum {IDLE, OWNED}.
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req vector and last_owner pointer.
  - Outputs: any_req, winner index, winner one-hot, multi_req flag.
  - Instantiated once.
- bus_source_encoder holds all registers, state, hold logic and counter.

Test Plan:
- Reset: clear = 1 with out_req = all ones -> sel = 0, grant = 0, bus_valid = 0, conflict = 0, conflict_count = 0 after the edge.
- Single source: out_req = bit 20 (PCout) for 1 cycle -> next cycle sel = 20, grant = 1<<20, bus_valid = 1. Then out_req = 0 -> bus_valid = 0, grant = 0, sel stays 20.
- Round-robin with wrap: from reset, out_req = bits {3, 21, 23} held, hold = 0 -> successive sel = 3, 21, 23, 3, with conflict = 1 and conflict_count incrementing each cycle.
- Hold: owner sel = 21 (MDR), hold = 1, out_req = {5, 21} -> sel stays 21. Drop bit 21 -> next sel = 5 despite hold = 1.
- Saturation and mid-operation reset: 300 consecutive conflict cycles -> conflict_count = 255, stays 255. Then assert clear while OWNED -> all outputs return to reset values on that edge, and the next arbitration with out_req = {0, 23} picks 0.

Source files
------------

// File: rtl/bus_source_encoder_pkg.sv
// Shared definitions for the datapath bus: source count, select width and the
// named select code of every bus source.
package bus_pkg;

    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;
    localparam int CNT_W   = 8;

    localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SRC_CSIGN  = 5'd23;

    typedef enum logic {
        IDLE,
        OWNED
    } busState_e;

endpackage

// File: rtl/bus_source_encoder_if.sv
// Control-to-encoder bundle: drive requests and hold in, select/grant/debug out.
interface bus_source_encoder_if;
    import bus_pkg::*;

    logic [NUM_SRC-1:0] out_req;
    logic               hold;
    logic [SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0] grant;
    logic               bus_valid;
    logic               conflict;
    logic [CNT_W-1:0]   conflict_count;

    modport master (
        output out_req,
        output hold,
        input  sel,
        input  grant,
        input  bus_valid,
        input  conflict,
        input  conflict_count
    );

    modport slave (
        input  out_req,
        input  hold,
        output sel,
        output grant,
        output bus_valid,
        output conflict,
        output conflict_count
    );

endinterface

// File: rtl/bus_source_encoder_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after lastOwner,
// wrapping from NUM_SRC-1 back to 0.
module rr_arbiter
    import bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   lastOwner,
    output logic               anyReq,
    output logic [SEL_W-1:0]   winner,
    output logic [NUM_SRC-1:0] winnerOneHot,
    output logic               multiReq
);

    logic [SEL_W:0] cand;

    assign anyReq   = |req;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multiReq = |(req & (req - NUM_SRC'(1)));

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = {1'b0, lastOwner} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_SRC)) begin
                cand = cand - (SEL_W+1)'(NUM_SRC);
            end
            if ((cand < (SEL_W+1)'(NUM_SRC)) && req[cand[SEL_W-1:0]]) begin
                winner = cand[SEL_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
            assign winnerOneHot[gi] = anyReq && (winner == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_source_encoder.sv
// Turns control Xout drive requests into a registered, always-legal bus select
// with round-robin arbitration, ownership hold and conflict accounting.
module bus_source_encoder
    import bus_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    bus_source_encoder_if.slave  bus
);

    busState_e          stateReg;
    logic [SEL_W-1:0]   selReg;
    logic [NUM_SRC-1:0] grantReg;
    logic [SEL_W-1:0]   lastOwnerReg;
    logic               conflictReg;
    logic [CNT_W-1:0]   countReg;

    logic               arbAny;
    logic [SEL_W-1:0]   arbWinner;
    logic [NUM_SRC-1:0] arbOneHot;
    logic               arbMulti;
    logic               keepOwner;

    rr_arbiter u_arbiter (
        .req          (bus.out_req),
        .lastOwner    (lastOwnerReg),
        .anyReq       (arbAny),
        .winner       (arbWinner),
        .winnerOneHot (arbOneHot),
        .multiReq     (arbMulti)
    );

    // grantReg is the one-hot of selReg while OWNED, so this tests out_req[sel].
    assign keepOwner = (stateReg == OWNED) && bus.hold && |(bus.out_req & grantReg);

    always_ff @(posedge clock) begin
        if (clear) begin
            stateReg     <= IDLE;
            selReg       <= '0;
            grantReg     <= '0;
            lastOwnerReg <= SEL_W'(NUM_SRC - 1);
            conflictReg  <= 1'b0;
            countReg     <= '0;
        end else begin
            conflictReg <= arbMulti;
            if (arbMulti && (countReg != {CNT_W{1'b1}})) begin
                countReg <= countReg + CNT_W'(1);
            end

            if (keepOwner) begin
                stateReg <= OWNED;
            end else if (arbAny) begin
                stateReg     <= OWNED;
                selReg       <= arbWinner;
                grantReg     <= arbOneHot;
                lastOwnerReg <= arbWinner;
            end else begin
                // selReg deliberately keeps its value so the mux stays deterministic.
                stateReg <= IDLE;
                grantReg <= '0;
            end
        end
    end

    assign bus.sel            = selReg;
    assign bus.grant          = grantReg;
    assign bus.bus_valid      = (stateReg == OWNED);
    assign bus.conflict       = conflictReg;
    assign bus.conflict_count = countReg;

endmodule
